// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT frame sequencer.
package fft_pkg;
    localparam int N_PTS  = 16;
    localparam int DATA_W = 34;
    localparam int HALF_W = 17;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Handshake and status bundle between the sample source, the datapath and fft_seq_ctrl.
interface fft_seq_ctrl_if;
    import fft_pkg::*;

    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             dp_en;
    logic             dp_start;
    logic [IDX_W-1:0] in_idx;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             frame_done;
    logic             err;

    modport master (
        output in_valid, in_last,
        input  in_ready, dp_en, dp_start, in_idx,
        input  out_valid, out_idx, out_last, frame_done, err
    );

    modport slave (
        input  in_valid, in_last,
        output in_ready, dp_en, dp_start, in_idx,
        output out_valid, out_idx, out_last, frame_done, err
    );
endinterface

// File: rtl/fft_valid_pipe.sv
// Shadow of the datapath pipeline: one valid bit per stage, advancing with the datapath enable.
module fft_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr;

    // Shift expressed without part-selects so DEPTH == 1 elaborates cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sr <= '0;
        else if (clr)
            sr <= '0;
        else if (en)
            sr <= (sr << 1) | DEPTH'(din);
    end

    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for a streaming FFT: admits N_PTS samples, drains the datapath, tracks result order.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int PIPE_LAT = 1,
    parameter int N_PTS    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    fft_seq_ctrl_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_PTS - 1);
    localparam logic [4:0]       DRAIN_LAST = 5'(PIPE_LAT - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] in_cnt, in_cnt_nxt, out_cnt;
    logic [4:0]       drain_cnt, drain_cnt_nxt;
    logic             run, ready, accept, adv, adv_q, start;
    logic             tail, out_valid, out_last, frame_done, err, frame_err;

    always_comb begin
        state_nxt     = state;
        in_cnt_nxt    = in_cnt;
        drain_cnt_nxt = drain_cnt;
        start         = 1'b0;
        // clr masks ready so a same-cycle sample is never taken.
        ready         = run & ~clr & (state != S_DRAIN);
        accept        = bus.in_valid & ready;
        adv           = accept;
        case (state)
            S_IDLE: if (accept) begin
                state_nxt  = S_LOAD;
                start      = 1'b1;
                in_cnt_nxt = in_cnt + 1'b1;
            end
            S_LOAD: if (accept) begin
                in_cnt_nxt = in_cnt + 1'b1;
                if (in_cnt == LAST_IDX) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                adv = ~clr;
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt     = S_IDLE;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (clr) begin
            state_nxt     = S_IDLE;
            in_cnt_nxt    = '0;
            drain_cnt_nxt = '0;
        end
    end

    // in_last is only checked against the count; sequencing ignores it.
    assign frame_err = accept & (bus.in_last != (in_cnt == LAST_IDX));

    fft_valid_pipe #(.DEPTH(PIPE_LAT)) u_vpipe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (adv),
        .din   (accept),
        .dout  (tail)
    );

    // The tail only counts as a new result on the cycle after it was loaded.
    assign out_valid = tail & adv_q;
    assign out_last  = out_valid & (out_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            in_cnt     <= '0;
            drain_cnt  <= '0;
            run        <= 1'b0;
            adv_q      <= 1'b0;
            out_cnt    <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_cnt     <= in_cnt_nxt;
            drain_cnt  <= drain_cnt_nxt;
            run        <= 1'b1;
            adv_q      <= adv;
            frame_done <= out_last & ~clr;
            if (clr)
                out_cnt <= '0;
            else if (out_valid)
                out_cnt <= out_cnt + 1'b1;
            if (frame_err)
                err <= 1'b1;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.dp_en      = adv;
    assign bus.dp_start   = start;
    assign bus.in_idx     = in_cnt;
    assign bus.out_valid  = out_valid;
    assign bus.out_idx    = out_cnt;
    assign bus.out_last   = out_last;
    assign bus.frame_done = frame_done;
    assign bus.err        = err;
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Two sequencers (PIPE_LAT 1 and 4) on shared stimulus, checked every cycle against a frame-level model.
module tb_fft_seq_ctrl;
    import fft_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    always #5 clk = ~clk;

    fft_seq_ctrl_if b1 ();
    fft_seq_ctrl_if b4 ();
    assign b1.in_valid = in_valid;
    assign b1.in_last  = in_last;
    assign b4.in_valid = in_valid;
    assign b4.in_last  = in_last;

    fft_seq_ctrl #(.PIPE_LAT(1), .N_PTS(16)) u1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(b1.slave));
    fft_seq_ctrl #(.PIPE_LAT(4), .N_PTS(16)) u4 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(b4.slave));

    logic [1:0] o_rdy, o_en, o_st, o_ov, o_ol, o_fd, o_err;
    logic [3:0] o_iidx [2];
    logic [3:0] o_oidx [2];
    assign o_rdy = {b4.in_ready, b1.in_ready};
    assign o_en  = {b4.dp_en, b1.dp_en};
    assign o_st  = {b4.dp_start, b1.dp_start};
    assign o_ov  = {b4.out_valid, b1.out_valid};
    assign o_ol  = {b4.out_last, b1.out_last};
    assign o_fd  = {b4.frame_done, b1.frame_done};
    assign o_err = {b4.err, b1.err};
    assign o_iidx[0] = b1.in_idx;
    assign o_iidx[1] = b4.in_idx;
    assign o_oidx[0] = b1.out_idx;
    assign o_oidx[1] = b4.out_idx;

    int n_cmp = 0, n_bad = 0;
    int lat [2] = '{1, 4};

    // Model: samples taken this frame (16 = draining), drain cycles spent, history of advance bits.
    int m_cnt [2], m_dl [2], m_outn [2];
    bit m_up [2], m_adv [2], m_fd [2], m_err [2];
    bit m_hist [2][16];
    int t_ov [2], t_fd [2], t_rlo [2], t_acc [2], t_st [2], t_enlo [2];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit rdy, acc, en, st, ov, ol, e_nxt;
            if (!rst_n) begin
                m_cnt[d] = 0; m_dl[d] = 0; m_outn[d] = 0;
                m_up[d] = 0; m_adv[d] = 0; m_fd[d] = 0; m_err[d] = 0;
                for (int k = 0; k < 16; k++) m_hist[d][k] = 0;
            end
            rdy   = rst_n && m_up[d] && !clr && (m_cnt[d] < 16);
            acc   = in_valid && rdy;
            en    = acc || (rst_n && m_cnt[d] == 16 && !clr);
            st    = acc && (m_cnt[d] == 0);
            ov    = m_adv[d] && m_hist[d][lat[d]-1];
            ol    = ov && (m_outn[d] % 16 == 15);
            e_nxt = m_err[d] || (acc && (in_last != (m_cnt[d] == 15)));

            chk("in_ready",   d, 32'(o_rdy[d]),  32'(rdy));
            chk("dp_en",      d, 32'(o_en[d]),   32'(en));
            chk("dp_start",   d, 32'(o_st[d]),   32'(st));
            chk("in_idx",     d, 32'(o_iidx[d]), 32'(m_cnt[d] % 16));
            chk("out_valid",  d, 32'(o_ov[d]),   32'(ov));
            chk("out_idx",    d, 32'(o_oidx[d]), 32'(m_outn[d] % 16));
            chk("out_last",   d, 32'(o_ol[d]),   32'(ol));
            chk("frame_done", d, 32'(o_fd[d]),   32'(m_fd[d]));
            chk("err",        d, 32'(o_err[d]),  32'(m_err[d]));

            if (rst_n) begin
                if (o_ov[d] === 1'b1) t_ov[d]++;
                if (o_fd[d] === 1'b1) t_fd[d]++;
                if (o_rdy[d] !== 1'b1) t_rlo[d]++;
                if (o_en[d] !== 1'b1) t_enlo[d]++;
                if (o_st[d] === 1'b1) t_st[d]++;
                if (in_valid && o_rdy[d] === 1'b1) t_acc[d]++;

                if (clr) begin
                    m_cnt[d] = 0; m_dl[d] = 0; m_outn[d] = 0; m_adv[d] = 0; m_fd[d] = 0;
                    for (int k = 0; k < 16; k++) m_hist[d][k] = 0;
                end else begin
                    if (m_cnt[d] == 16) begin
                        m_dl[d]++;
                        if (m_dl[d] == lat[d]) begin m_cnt[d] = 0; m_dl[d] = 0; end
                    end else if (acc) begin
                        m_cnt[d]++;
                    end
                    if (en) begin
                        for (int k = 15; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
                        m_hist[d][0] = acc;
                    end
                    m_adv[d] = en;
                    if (ov) m_outn[d]++;
                    m_fd[d] = ol;
                end
                m_up[d]  = 1;
                m_err[d] = e_nxt;
            end
        end
    end

    task automatic step(input logic v, input logic l, input logic c);
        in_valid = v; in_last = l; clr = c;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic tally_clear();
        for (int d = 0; d < 2; d++) begin
            t_ov[d] = 0; t_fd[d] = 0; t_rlo[d] = 0; t_acc[d] = 0; t_st[d] = 0; t_enlo[d] = 0;
        end
    endtask

    initial begin
        idle(3);
        for (int d = 0; d < 2; d++) chk("rst_ready", d, 32'(o_rdy[d]), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Back-to-back frame
        tally_clear();
        for (int k = 0; k < 16; k++) step(1'b1, k == 15, 1'b0);
        idle(8);
        for (int d = 0; d < 2; d++) begin
            chk("b2b_ov_cnt", d, 32'(t_ov[d]), 32'd16);
            chk("b2b_fd_cnt", d, 32'(t_fd[d]), 32'd1);
        end
        chk("b2b_rdy_low", 0, 32'(t_rlo[0]), 32'd1);
        chk("b2b_rdy_low", 1, 32'(t_rlo[1]), 32'd4);

        // Input gaps after samples 4 and 9
        tally_clear();
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k == 15, 1'b0);
            if (k == 4 || k == 9) idle(3);
        end
        idle(8);
        for (int d = 0; d < 2; d++) begin
            chk("gap_ov_cnt", d, 32'(t_ov[d]), 32'd16);
            chk("gap_fd_cnt", d, 32'(t_fd[d]), 32'd1);
        end
        chk("gap_en_low", 0, 32'(t_enlo[0]), 32'd13);
        chk("gap_en_low", 1, 32'(t_enlo[1]), 32'd10);

        // Early in_last
        tally_clear();
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k == 7, 1'b0);
            if (k == 6) for (int d = 0; d < 2; d++) chk("err_pre", d, 32'(o_err[d]), 32'd0);
            if (k == 7) for (int d = 0; d < 2; d++) chk("err_set", d, 32'(o_err[d]), 32'd1);
        end
        idle(8);
        for (int d = 0; d < 2; d++) chk("err_fd_cnt", d, 32'(t_fd[d]), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        for (int d = 0; d < 2; d++) chk("err_after_clr", d, 32'(o_err[d]), 32'd1);

        // clr with in_valid mid-LOAD
        tally_clear();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk("clr_ov", d, 32'(o_ov[d]), 32'd0);
            chk("clr_idx", d, 32'(o_iidx[d]), 32'd0);
        end
        idle(8);
        for (int d = 0; d < 2; d++) begin
            chk("clr_fd_cnt", d, 32'(t_fd[d]), 32'd0);
            chk("clr_acc_cnt", d, 32'(t_acc[d]), 32'd5);
        end
        chk("clr_ov_cnt", 0, 32'(t_ov[0]), 32'd5);
        chk("clr_ov_cnt", 1, 32'(t_ov[1]), 32'd2);

        // Reset during sample 8
        tally_clear();
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk("mrst_err", d, 32'(o_err[d]), 32'd0);
            chk("mrst_ready", d, 32'(o_rdy[d]), 32'd0);
            chk("mrst_ov", d, 32'(o_ov[d]), 32'd0);
        end
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) step(1'b1, k == 15, 1'b0);
        idle(8);
        for (int d = 0; d < 2; d++) begin
            chk("mrst_fd_cnt", d, 32'(t_fd[d]), 32'd1);
            chk("mrst_st_cnt", d, 32'(t_st[d]), 32'd2);
        end

        // in_valid held high across DRAIN
        tally_clear();
        for (int k = 0; k < 22; k++) step(1'b1, k == 15, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("hold_acc_cnt", 0, 32'(t_acc[0]), 32'd21);
        chk("hold_acc_cnt", 1, 32'(t_acc[1]), 32'd18);
        chk("hold_rdy_low", 0, 32'(t_rlo[0]), 32'd1);
        chk("hold_rdy_low", 1, 32'(t_rlo[1]), 32'd4);
        for (int d = 0; d < 2; d++) chk("hold_st_cnt", d, 32'(t_st[d]), 32'd2);

        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
